decode_cycle: RTL and testbench
===============================

// Module: decode_cycle
// PURPOSE
//  RV32I decode stage, directly downstream of the fetch stage; consumes instr_D/PCD/PCPlusD from the IF/ID register.
//  Contains the main + ALU control decoders, immediate extender and a 32x32 register file written from writeback.
//  Drives the ID/EX pipeline register feeding the execute stage.
// PARAMETERS
//  DATA_W   32  datapath / register width
//  REG_AW   5   register index width (2**REG_AW registers)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous reset, active-high
//  instr_D      in   32      instruction from IF/ID
//  PCD          in   32      PC of instr_D
//  PCPlusD      in   32      PCD+4
//  RegWriteW    in   1       writeback register write enable
//  RDW          in   5       writeback destination index
//  ResultW      in   32      writeback data
//  RegWriteE    out  1       register write enable to EX
//  ResultSrcE   out  2       00 ALU, 01 memory, 10 PC+4
//  MemWriteE    out  1       store enable
//  JumpE        out  1       jal
//  BranchE      out  1       beq
//  ALUSrcE      out  1       0 RD2, 1 immediate
//  ALUControlE  out  3       000 add, 001 sub, 010 and, 011 or, 101 slt
//  RD1_E        out  32      rs1 data
//  RD2_E        out  32      rs2 data
//  Imm_Ext_E    out  32      sign-extended immediate
//  RD_E         out  5       instr[11:7]
//  RS1_E        out  5       instr[19:15]
//  RS2_E        out  5       instr[24:20]
//  PCE, PCPlusE out  32 ea.  PCD, PCPlusD delayed one cycle
// BEHAVIOUR
//  - Latency 1 cycle: decode is combinational on instr_D; all *_E outputs are registered on posedge clk.
//  - Reset: every ID/EX register and all 32 register-file entries clear to 0 on posedge with rst=1.
//    All outputs are also forced to 0 combinationally while rst=1.
//  - Opcodes:
//    lw     0000011: RegWrite=1, ResultSrc=01, ALUSrc=1, ImmSrc=I
//    sw     0100011: MemWrite=1, ALUSrc=1, ImmSrc=S
//    R-type 0110011: RegWrite=1
//    I-ALU  0010011: RegWrite=1, ALUSrc=1, ImmSrc=I
//    beq    1100011: Branch=1, ALU sub, ImmSrc=B
//    jal    1101111: RegWrite=1, Jump=1, ResultSrc=10, ImmSrc=J
//  - Any other opcode, including the reset bubble 0x00000000: all control 0 (NOP). Data fields still register.
//  - ALU decoder:
//    funct3 000: sub only if R-type and funct7[5]=1, else add
//    funct3 010: slt;  110: or;  111: and;  other: add
//  - Immediates: I={20{i31},i[31:20]}; S={20{i31},i[31:25],i[11:7]};
//    B={19{i31},i31,i7,i[30:25],i[11:8],0}; J={11{i31},i31,i[19:12],i20,i[30:21],0}.
//  - Register file: posedge write when RegWriteW=1 and RDW!=0. Writes to x0 are ignored; x0 always reads 0.
//    Write-through: same-cycle read of RDW (RDW!=0, RegWriteW=1) returns ResultW.
// CONFIGURATION
//  DECODE_FLUSH_EN defined: adds input FlushE (1 bit). With FlushE=1 at posedge, all ID/EX control
//    registers load 0 (bubble); data and index registers still load. rst has priority over FlushE.
//  Not defined: no FlushE port; ID/EX register loads every cycle.
// TESTING
//  - rst=1 for 2 cycles with arbitrary instr_D -> all outputs 0. After release, reading x1..x31 returns 0.
//  - Write x5=0xDEADBEEF via W port, then instr_D=add x7,x5,x0 (0x000283B3) in the same cycle
//    -> RD1_E=0xDEADBEEF, ALUControlE=000, RegWriteE=1, RD_E=7.
//  - RegWriteW=1, RDW=0, ResultW=0x1234; then read x0 -> RD1_E=0.
//  - lw x1,-4(x2) (0xFFC12083) -> Imm_Ext_E=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1.
//    sw x3,8(x2) (0x00312423) -> Imm_Ext_E=8, MemWriteE=1, RegWriteE=0.
//  - beq x1,x2,-8 (0xFE208CE3) -> BranchE=1, ALUControlE=001, Imm_Ext_E=0xFFFFFFF8.
//    jal x1,16 (0x010000EF) -> JumpE=1, ResultSrcE=10, Imm_Ext_E=16, PCPlusE=PCD+4 delayed.
//  - DECODE_FLUSH_EN: FlushE=1 with R-type in decode -> next cycle RegWriteE=0, RD_E=instr[11:7].
//    Illegal opcode 0x0000007F -> all control 0.

Source files
------------

// File: rtl/decode_cycle.sv
// RV32I decode stage: main decoder, ALU decoder, immediate extender and a
// 32-entry register file, feeding the ID/EX pipeline register.
// Optional feature macro: DECODE_FLUSH_EN adds a FlushE input that turns the
// next ID/EX control word into a bubble while data fields still load.
// No state machine here; every *_E output is a plain pipeline register.
module decode_cycle #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_D,
  input  logic [DATA_W-1:0] PCD,
  input  logic [DATA_W-1:0] PCPlusD,
`ifdef DECODE_FLUSH_EN
  input  logic              FlushE,
`endif
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [DATA_W-1:0] ResultW,
  output logic              RegWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic [DATA_W-1:0] RD1_E,
  output logic [DATA_W-1:0] RD2_E,
  output logic [DATA_W-1:0] Imm_Ext_E,
  output logic [REG_AW-1:0] RD_E,
  output logic [REG_AW-1:0] RS1_E,
  output logic [REG_AW-1:0] RS2_E,
  output logic [DATA_W-1:0] PCE,
  output logic [DATA_W-1:0] PCPlusE
);

  localparam int NREGS = 2 ** REG_AW;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic [REG_AW-1:0] rs1, rs2, rd;

  assign opcode   = instr_D[6:0];
  assign funct3   = instr_D[14:12];
  assign funct7_5 = instr_D[30];
  assign rs1      = instr_D[15 +: REG_AW];
  assign rs2      = instr_D[20 +: REG_AW];
  assign rd       = instr_D[7 +: REG_AW];

  // Decoded control word for the instruction currently in decode
  logic       reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, is_rtype;
  logic [1:0] result_src_d, imm_src, alu_op;
  logic [2:0] alu_ctrl_d;

  // Main decoder: unknown opcodes (including the all-zero bubble) decode as NOP
  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    result_src_d = 2'b00;
    imm_src      = 2'b00;
    alu_op       = 2'b00;
    is_rtype     = 1'b0;
    case (opcode)
      7'b0000011: begin // lw
        reg_write_d  = 1'b1;
        result_src_d = 2'b01;
        alu_src_d    = 1'b1;
        imm_src      = 2'b00;
      end
      7'b0100011: begin // sw
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src     = 2'b01;
      end
      7'b0110011: begin // R-type
        reg_write_d = 1'b1;
        alu_op      = 2'b10;
        is_rtype    = 1'b1;
      end
      7'b0010011: begin // I-type ALU
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src     = 2'b00;
        alu_op      = 2'b10;
      end
      7'b1100011: begin // beq
        branch_d = 1'b1;
        imm_src  = 2'b10;
        alu_op   = 2'b01;
      end
      7'b1101111: begin // jal
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        result_src_d = 2'b10;
        imm_src      = 2'b11;
      end
      default: ;
    endcase
  end

  // ALU decoder: loads/stores add, beq subtracts, ALU ops decode funct3/funct7
  always_comb begin
    alu_ctrl_d = 3'b000;
    case (alu_op)
      2'b01:   alu_ctrl_d = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctrl_d = (is_rtype && funct7_5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl_d = 3'b101;
          3'b110:  alu_ctrl_d = 3'b011;
          3'b111:  alu_ctrl_d = 3'b010;
          default: alu_ctrl_d = 3'b000;
        endcase
      end
      default: alu_ctrl_d = 3'b000;
    endcase
  end

  // Immediate extender selected by the main decoder's immediate format
  logic [DATA_W-1:0] imm_ext_d;
  always_comb begin
    imm_ext_d = '0;
    case (imm_src)
      2'b00: imm_ext_d = {{(DATA_W-12){instr_D[31]}}, instr_D[31:20]};
      2'b01: imm_ext_d = {{(DATA_W-12){instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
      2'b10: imm_ext_d = {{(DATA_W-12){instr_D[31]}}, instr_D[7], instr_D[30:25],
                          instr_D[11:8], 1'b0};
      default: imm_ext_d = {{(DATA_W-20){instr_D[31]}}, instr_D[19:12], instr_D[20],
                            instr_D[30:21], 1'b0};
    endcase
  end

  // Register file storage
  logic [DATA_W-1:0] rf [NREGS];
  logic              wr_en;
  assign wr_en = RegWriteW && (RDW != '0);

  // Register file write port; x0 is never written, reset clears every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[RDW] <= ResultW;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write to the read index forwards ResultW
  logic [DATA_W-1:0] rd1_d, rd2_d;
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1 != '0) rd1_d = (wr_en && RDW == rs1) ? ResultW : rf[rs1];
    if (rs2 != '0) rd2_d = (wr_en && RDW == rs2) ? ResultW : rf[rs2];
  end

  logic flush;
`ifdef DECODE_FLUSH_EN
  assign flush = FlushE;
`else
  assign flush = 1'b0;
`endif

  // ID/EX pipeline register
  logic              reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
  logic [1:0]        result_src_q;
  logic [2:0]        alu_ctrl_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q, pc_q, pc_plus_q;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;

  // ID/EX load: reset clears all, flush clears only the control word
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      jump_q       <= 1'b0;
      branch_q     <= 1'b0;
      alu_src_q    <= 1'b0;
      result_src_q <= 2'b00;
      alu_ctrl_q   <= 3'b000;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      pc_plus_q    <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
    end else begin
      reg_write_q  <= flush ? 1'b0   : reg_write_d;
      mem_write_q  <= flush ? 1'b0   : mem_write_d;
      jump_q       <= flush ? 1'b0   : jump_d;
      branch_q     <= flush ? 1'b0   : branch_d;
      alu_src_q    <= flush ? 1'b0   : alu_src_d;
      result_src_q <= flush ? 2'b00  : result_src_d;
      alu_ctrl_q   <= flush ? 3'b000 : alu_ctrl_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_ext_d;
      pc_q         <= PCD;
      pc_plus_q    <= PCPlusD;
      rd_q         <= rd;
      rs1_q        <= rs1;
      rs2_q        <= rs2;
    end
  end

  // Outputs are held at zero for as long as reset is asserted
  assign RegWriteE   = rst ? 1'b0   : reg_write_q;
  assign ResultSrcE  = rst ? 2'b00  : result_src_q;
  assign MemWriteE   = rst ? 1'b0   : mem_write_q;
  assign JumpE       = rst ? 1'b0   : jump_q;
  assign BranchE     = rst ? 1'b0   : branch_q;
  assign ALUSrcE     = rst ? 1'b0   : alu_src_q;
  assign ALUControlE = rst ? 3'b000 : alu_ctrl_q;
  assign RD1_E       = rst ? '0     : rd1_q;
  assign RD2_E       = rst ? '0     : rd2_q;
  assign Imm_Ext_E   = rst ? '0     : imm_q;
  assign RD_E        = rst ? '0     : rd_q;
  assign RS1_E       = rst ? '0     : rs1_q;
  assign RS2_E       = rst ? '0     : rs2_q;
  assign PCE         = rst ? '0     : pc_q;
  assign PCPlusE     = rst ? '0     : pc_plus_q;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: reset, register file, decoders, immediates.
// Build with DECODE_FLUSH_EN defined to also exercise the flush input.
module tb_decode_cycle;

  logic        clk;
  logic        rst;
  logic [31:0] instr_D, PCD, PCPlusD, ResultW;
  logic        RegWriteW;
  logic [4:0]  RDW;
`ifdef DECODE_FLUSH_EN
  logic        FlushE;
`endif
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlusE;
  logic [4:0]  RD_E, RS1_E, RS2_E;

  int n_checks = 0;
  int n_pass   = 0;

  decode_cycle dut (
    .clk         (clk),
    .rst         (rst),
    .instr_D     (instr_D),
    .PCD         (PCD),
    .PCPlusD     (PCPlusD),
`ifdef DECODE_FLUSH_EN
    .FlushE      (FlushE),
`endif
    .RegWriteW   (RegWriteW),
    .RDW         (RDW),
    .ResultW     (ResultW),
    .RegWriteE   (RegWriteE),
    .ResultSrcE  (ResultSrcE),
    .MemWriteE   (MemWriteE),
    .JumpE       (JumpE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .RD1_E       (RD1_E),
    .RD2_E       (RD2_E),
    .Imm_Ext_E   (Imm_Ext_E),
    .RD_E        (RD_E),
    .RS1_E       (RS1_E),
    .RS2_E       (RS2_E),
    .PCE         (PCE),
    .PCPlusE     (PCPlusE)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control word: {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, ALUControl[2:0]}
  function automatic logic [31:0] ctrl_vec();
    return {22'd0, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction with its PC to the decode stage
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    instr_D = ins;
    PCD     = pc;
    PCPlusD = pc + 32'd4;
  endtask

  initial begin
    rst       = 1'b1;
    RegWriteW = 1'b0;
    RDW       = 5'd0;
    ResultW   = 32'd0;
`ifdef DECODE_FLUSH_EN
    FlushE    = 1'b0;
`endif
    drive(32'h0101_00EF, 32'h0000_0040);

    // Reset held two cycles with a live instruction in decode
    step();
    check("rst1_ctrl", ctrl_vec(), 32'd0);
    check("rst1_pc", PCE, 32'd0);
    step();
    check("rst2_ctrl", ctrl_vec(), 32'd0);
    check("rst2_imm", Imm_Ext_E, 32'd0);
    check("rst2_pcplus", PCPlusE, 32'd0);
    check("rst2_rd", 32'(RD_E), 32'd0);
    rst = 1'b0;

    // Every register reads zero after reset (rs1 = i, rs2 = 32-i)
    for (int i = 1; i < 32; i++) begin
      drive({7'd0, 5'(32 - i), 5'(i), 3'b000, 5'd1, 7'b0110011}, 32'd0);
      step();
      check($sformatf("rf_rst_rs1_x%0d", i), RD1_E, 32'd0);
      check($sformatf("rf_rst_rs2_x%0d", 32 - i), RD2_E, 32'd0);
    end

    // Write x5 and read it through the write-through path in the same cycle
    RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hDEAD_BEEF;
    drive(32'h0002_83B3, 32'h0000_0100); // add x7,x5,x0
    step();
    check("wt_rd1", RD1_E, 32'hDEAD_BEEF);
    check("add_ctrl", ctrl_vec(), 32'b1_00_0_0_0_0_000);
    check("add_rd", 32'(RD_E), 32'd7);
    check("add_rs1", 32'(RS1_E), 32'd5);
    check("add_rs2_data", RD2_E, 32'd0);
    check("add_pc", PCE, 32'h0000_0100);

    // Same read from storage with the write port idle
    RegWriteW = 1'b0; ResultW = 32'h0;
    step();
    check("rf_store_x5", RD1_E, 32'hDEAD_BEEF);

    // Write to x0 is ignored both on the forward path and in storage
    RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h0000_1234;
    drive(32'h0000_03B3, 32'h0000_0104); // add x7,x0,x0
    step();
    check("x0_wt", RD1_E, 32'd0);
    RegWriteW = 1'b0;
    step();
    check("x0_store", RD1_E, 32'd0);

    // Put 0x00000055 in x6 for the R-type rs2 reads
    RegWriteW = 1'b1; RDW = 5'd6; ResultW = 32'h0000_0055;
    drive(32'h4062_8433, 32'h0000_0108); // sub x8,x5,x6
    step();
    RegWriteW = 1'b0;
    check("sub_ctrl", ctrl_vec(), 32'b1_00_0_0_0_0_001);
    check("sub_rd2", RD2_E, 32'h0000_0055);
    check("sub_rs2", 32'(RS2_E), 32'd6);

    drive(32'h4002_8493, 32'h0000_010C); // addi x9,x5,0x400 (bit30 set, still add)
    step();
    check("addi_ctrl", ctrl_vec(), 32'b1_00_0_0_0_1_000);
    check("addi_imm", Imm_Ext_E, 32'h0000_0400);

    drive(32'h0FF2_E513, 32'h0000_0110); // ori x10,x5,0xFF
    step();
    check("ori_ctrl", ctrl_vec(), 32'b1_00_0_0_0_1_011);
    check("ori_imm", Imm_Ext_E, 32'h0000_00FF);

    drive(32'h0062_A5B3, 32'h0000_0114); // slt x11,x5,x6
    step();
    check("slt_ctrl", ctrl_vec(), 32'b1_00_0_0_0_0_101);

    drive(32'h0062_F633, 32'h0000_0118); // and x12,x5,x6
    step();
    check("and_ctrl", ctrl_vec(), 32'b1_00_0_0_0_0_010);

    // Loads and stores
    drive(32'hFFC1_2083, 32'h0000_011C); // lw x1,-4(x2)
    step();
    check("lw_imm", Imm_Ext_E, 32'hFFFF_FFFC);
    check("lw_rsrc", 32'(ResultSrcE), 32'd1);
    check("lw_alusrc", 32'(ALUSrcE), 32'd1);
    check("lw_regwr", 32'(RegWriteE), 32'd1);
    check("lw_memwr", 32'(MemWriteE), 32'd0);
    check("lw_rd", 32'(RD_E), 32'd1);

    drive(32'h0031_2423, 32'h0000_0120); // sw x3,8(x2)
    step();
    check("sw_imm", Imm_Ext_E, 32'h0000_0008);
    check("sw_memwr", 32'(MemWriteE), 32'd1);
    check("sw_regwr", 32'(RegWriteE), 32'd0);
    check("sw_alusrc", 32'(ALUSrcE), 32'd1);

    // Branch and jump
    drive(32'hFE20_8CE3, 32'h0000_0124); // beq x1,x2,-8
    step();
    check("beq_ctrl", ctrl_vec(), 32'b0_00_0_0_1_0_001);
    check("beq_imm", Imm_Ext_E, 32'hFFFF_FFF8);

    drive(32'h0100_00EF, 32'h0000_0200); // jal x1,16
    step();
    check("jal_ctrl", ctrl_vec(), 32'b1_10_0_1_0_0_000);
    check("jal_imm", Imm_Ext_E, 32'h0000_0010);
    check("jal_pc", PCE, 32'h0000_0200);
    check("jal_pcplus", PCPlusE, 32'h0000_0204);

    // Illegal opcode and the all-zero bubble both decode as NOP
    drive(32'h0000_007F, 32'h0000_0204);
    step();
    check("illegal_ctrl", ctrl_vec(), 32'd0);
    drive(32'h0000_0FFF, 32'h0000_0208);
    step();
    check("illegal_rd_loads", 32'(RD_E), 32'd31);
    check("illegal_ctrl2", ctrl_vec(), 32'd0);
    drive(32'h0000_0000, 32'h0000_020C);
    step();
    check("bubble_ctrl", ctrl_vec(), 32'd0);
    check("bubble_pc", PCE, 32'h0000_020C);

`ifdef DECODE_FLUSH_EN
    // Flush kills the control word but data and indices still load
    FlushE = 1'b1;
    drive(32'h0002_83B3, 32'h0000_0300);
    step();
    FlushE = 1'b0;
    check("flush_ctrl", ctrl_vec(), 32'd0);
    check("flush_rd", 32'(RD_E), 32'd7);
    check("flush_rd1", RD1_E, 32'hDEAD_BEEF);
    check("flush_pc", PCE, 32'h0000_0300);
    step();
    check("unflush_ctrl", ctrl_vec(), 32'b1_00_0_0_0_0_000);
`endif

    // Mid-run reset: outputs drop at once, register file is cleared
    drive(32'h0100_00EF, 32'h0000_0400);
    step();
    check("pre_rst_jump", 32'(JumpE), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_comb_ctrl", ctrl_vec(), 32'd0);
    check("rst_comb_pc", PCE, 32'd0);
    step();
    rst = 1'b0;
    drive(32'h0002_83B3, 32'h0000_0404); // read x5 again
    step();
    check("rf_cleared_x5", RD1_E, 32'd0);
    check("post_rst_ctrl", ctrl_vec(), 32'b1_00_0_0_0_0_000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
